// File: rtl/adc_capture_sequencer.sv
// Capture-frame sequencer: arms the ADC capture block, waits for its RAM to fill,
// then streams a two-byte header and every RAM word (LSB first) toward the FT245 path.
module adc_capture_sequencer #(
  parameter int                ADDR_W    = 11,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 11'd2047,
  parameter logic [10:0]       DIV_RESET = 11'd4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_START,
  input  logic              CMD_CONT,
  input  logic              CMD_ABORT,
  input  logic [10:0]       CFG_DIV,
  output logic [10:0]       DIV_OUT,
  output logic              TURN_START,
  input  logic              TURN_DONE,
  output logic [ADDR_W-1:0] RAM_RD_ADDR,
  input  logic [31:0]       RAM_DATA,
  output logic [7:0]        TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic              BUSY,
  output logic [15:0]       FRAME_CNT
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_WAIT_DONE, S_HDR0, S_HDR1, S_RD_ADDR, S_RD_LATCH, S_SEND, S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic [10:0]       div_q, div_d;
  logic [15:0]       frame_q, frame_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q  <= '0;
      byte_q  <= '0;
      div_q   <= DIV_RESET;
      frame_q <= '0;
    end else begin
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      div_q   <= div_d;
      frame_q <= frame_d;
    end
  end

  // The word buffer is pure data; its content is meaningless until RD_LATCH fills it.
  always_ff @(posedge CLK) begin
    word_q <= word_d;
  end

  // Abort is evaluated first so it wins over start, turn-done and any handshake.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    byte_d  = byte_q;
    div_d   = div_q;
    frame_d = frame_q;
    if (CMD_ABORT) begin
      state_d = S_IDLE;
      addr_d  = '0;
      byte_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (CMD_START) begin
            div_d   = CFG_DIV;
            state_d = S_ARM;
          end
        end
        S_ARM:       state_d = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (TURN_DONE) begin
            addr_d  = '0;
            state_d = S_HDR0;
          end
        end
        S_HDR0:      if (TX_READY) state_d = S_HDR1;
        S_HDR1:      if (TX_READY) state_d = S_RD_ADDR;
        S_RD_ADDR:   state_d = S_RD_LATCH;
        S_RD_LATCH: begin
          word_d  = RAM_DATA;
          byte_d  = '0;
          state_d = S_SEND;
        end
        S_SEND: begin
          if (TX_READY) begin
            if (byte_q == 2'd3) begin
              byte_d = '0;
              if (addr_q == LAST_ADDR) begin
                state_d = S_NEXT;
              end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_RD_ADDR;
              end
            end else begin
              byte_d = byte_q + 1'b1;
            end
          end
        end
        S_NEXT: begin
          frame_d = frame_q + 1'b1;
          addr_d  = '0;
          state_d = CMD_CONT ? S_ARM : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pulses and valid are masked by abort in the same cycle so no byte is accepted then.
  always_comb begin
    TURN_START = 1'b0;
    TX_VALID   = 1'b0;
    TX_DATA    = 8'h00;
    case (state_q)
      S_ARM:  TURN_START = !CMD_ABORT;
      S_HDR0: begin
        TX_VALID = !CMD_ABORT;
        TX_DATA  = 8'hA5;
      end
      S_HDR1: begin
        TX_VALID = !CMD_ABORT;
        TX_DATA  = 8'h5A;
      end
      S_SEND: begin
        TX_VALID = !CMD_ABORT;
        TX_DATA  = word_q[{byte_q, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign BUSY        = (state_q != S_IDLE);
  assign DIV_OUT     = div_q;
  assign RAM_RD_ADDR = addr_q;
  assign FRAME_CNT   = frame_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: directed steps with randomized RAM contents and
// backpressure, checked against a byte-stream reference model of the frame format.
module tb_adc_capture_sequencer;

  localparam int ADDR_W = 11;
  localparam int LAST   = 127;
  localparam int NWORDS = LAST + 1;
  localparam int FLEN   = 2 + 4 * NWORDS;

  logic              CLK = 1'b0;
  logic              RST;
  logic              CMD_START, CMD_CONT, CMD_ABORT;
  logic [10:0]       CFG_DIV;
  logic [10:0]       DIV_OUT;
  logic              TURN_START;
  logic              TURN_DONE;
  logic [ADDR_W-1:0] RAM_RD_ADDR;
  logic [31:0]       RAM_DATA;
  logic [7:0]        TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic              BUSY;
  logic [15:0]       FRAME_CNT;

  adc_capture_sequencer #(
    .ADDR_W   (ADDR_W),
    .LAST_ADDR(11'(LAST)),
    .DIV_RESET(11'd4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CMD_START  (CMD_START),
    .CMD_CONT   (CMD_CONT),
    .CMD_ABORT  (CMD_ABORT),
    .CFG_DIV    (CFG_DIV),
    .DIV_OUT    (DIV_OUT),
    .TURN_START (TURN_START),
    .TURN_DONE  (TURN_DONE),
    .RAM_RD_ADDR(RAM_RD_ADDR),
    .RAM_DATA   (RAM_DATA),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .BUSY       (BUSY),
    .FRAME_CNT  (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Synchronous RAM: data appears one cycle after the address.
  logic [31:0] mem [0:2047];
  always @(posedge CLK) RAM_DATA <= mem[RAM_RD_ADDR];

  // Observation queues filled by the monitor.
  logic [7:0] got[$];
  int got_cyc[$];
  int ts_cyc[$];
  int fc_log[$];
  int stab_viol = 0, div_viol = 0, addr_viol = 0;
  logic pv = 1'b0, pr = 1'b0, pbusy = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [10:0] pdiv = 11'd0;
  logic [15:0] pfc = 16'd0;

  always @(negedge CLK) begin
    if (RST) begin
      if (TX_VALID && TX_READY) begin
        got.push_back(TX_DATA);
        got_cyc.push_back(cyc);
      end
      if (TURN_START) ts_cyc.push_back(cyc);
      if (pv && !pr && !CMD_ABORT && (!TX_VALID || TX_DATA !== pd)) stab_viol++;
      if (pbusy && BUSY && DIV_OUT !== pdiv) div_viol++;
      if (int'(RAM_RD_ADDR) > LAST) addr_viol++;
      if (FRAME_CNT !== pfc) fc_log.push_back(int'(FRAME_CNT));
    end
    pv    <= TX_VALID;
    pr    <= TX_READY;
    pd    <= TX_DATA;
    pbusy <= BUSY;
    pdiv  <= DIV_OUT;
    pfc   <= FRAME_CNT;
  end

  // Capture block model: TURN_DONE 20 cycles after each TURN_START.
  initial begin
    TURN_DONE = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST && TURN_START) begin
        repeat (20) @(posedge CLK);
        #1 TURN_DONE = 1'b1;
        @(posedge CLK);
        #1 TURN_DONE = 1'b0;
      end
    end
  end

  // Random sink backpressure when enabled.
  bit bp_en = 1'b0;
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (bp_en) TX_READY = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: header then each word LSB first.
  logic [7:0] exp_q[$];
  function automatic void build_exp();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int a = 0; a < NWORDS; a++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(mem[a] >> (8 * b)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk_stream(input string tag, input int base);
    int nbad = 0;
    build_exp();
    for (int i = 0; i < FLEN; i++)
      if (base + i >= got.size()) nbad++;
      else if (got[base + i] !== exp_q[i]) nbad++;
    chk(tag, nbad, 0);
  endtask

  task automatic wait_frame_end(input int target, input int budget, input string tag);
    int n = 0;
    while (!(int'(FRAME_CNT) == target && !BUSY) && n < budget) begin
      step();
      n++;
    end
    chk(tag, (n < budget), 1);
  endtask

  task automatic pulse_start(input logic [10:0] div);
    CFG_DIV   = div;
    CMD_START = 1'b1;
    step();
    CMD_START = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_div"},   DIV_OUT, 11'd4);
    chk({tag, "_ts"},    TURN_START, 1'b0);
    chk({tag, "_addr"},  RAM_RD_ADDR, '0);
    chk({tag, "_data"},  TX_DATA, 8'h00);
    chk({tag, "_valid"}, TX_VALID, 1'b0);
    chk({tag, "_busy"},  BUSY, 1'b0);
    chk({tag, "_fcnt"},  FRAME_CNT, 16'd0);
  endtask

  initial begin
    int n;
    logic [10:0] div_exp;
    RST = 1'b0; CMD_START = 1'b0; CMD_CONT = 1'b0; CMD_ABORT = 1'b0;
    CFG_DIV = 11'd0; TX_READY = 1'b1;
    for (int a = 0; a < 2048; a++) mem[a] = 32'(a) * 32'h01010101;

    step(3);
    chk_reset_outputs("rst");
    RST = 1'b1;
    step(2);
    chk("rst_release_busy", BUSY, 1'b0);

    // Single frame with READY held high.
    got.delete(); got_cyc.delete(); ts_cyc.delete();
    pulse_start(11'd9);
    CFG_DIV = 11'h3FF;
    wait_frame_end(1, 3000, "single_timeout");
    chk("single_div", DIV_OUT, 11'd9);
    chk("single_turns", ts_cyc.size(), 1);
    chk("single_len", got.size(), FLEN);
    chk_stream("single_stream", 0);
    chk("single_fcnt", FRAME_CNT, 16'd1);
    chk("single_done_lat", got_cyc[0] - ts_cyc[0], 21);
    chk("single_word_cost", got_cyc[6] - got_cyc[2], 6);
    chk("single_last_byte", got[FLEN-1], 8'(LAST));

    // Backpressure with random RAM contents.
    for (int a = 0; a < NWORDS; a++) mem[a] = $urandom;
    got.delete();
    div_exp = 11'($urandom_range(0, 2047));
    bp_en = 1'b1;
    pulse_start(div_exp);
    wait_frame_end(2, 10000, "bp_timeout");
    bp_en = 1'b0;
    step();
    TX_READY = 1'b1;
    chk("bp_len", got.size(), FLEN);
    chk_stream("bp_stream", 0);
    chk("bp_stable", stab_viol, 0);
    chk("bp_div", DIV_OUT, div_exp);
    chk("bp_fcnt", FRAME_CNT, 16'd2);

    // Continuous mode: three frames, then abort.
    got.delete(); got_cyc.delete(); ts_cyc.delete(); fc_log.delete();
    CMD_CONT = 1'b1;
    pulse_start(11'd33);
    n = 0;
    while (FRAME_CNT != 16'd5 && n < 8000) begin
      step();
      n++;
    end
    chk("cont_timeout", (n < 8000), 1);
    CMD_ABORT = 1'b1;
    step();
    CMD_ABORT = 1'b0;
    CMD_CONT = 1'b0;
    step(3);
    chk("cont_fc_n", fc_log.size(), 3);
    chk("cont_fc0", fc_log[0], 3);
    chk("cont_fc1", fc_log[1], 4);
    chk("cont_fc2", fc_log[2], 5);
    chk("cont_rearm_gap", ts_cyc[1] - got_cyc[FLEN-1], 2);
    chk_stream("cont_stream0", 0);
    chk_stream("cont_stream1", FLEN);
    chk_stream("cont_stream2", 2 * FLEN);
    chk("cont_abort_busy", BUSY, 1'b0);
    chk("cont_abort_fcnt", FRAME_CNT, 16'd5);
    chk("cont_div", DIV_OUT, 11'd33);

    // Abort during SEND at address 100.
    pulse_start(11'd12);
    n = 0;
    while (!(RAM_RD_ADDR == 11'd100 && TX_VALID) && n < 3000) begin
      step();
      n++;
    end
    chk("abort_reach", (n < 3000), 1);
    CMD_ABORT = 1'b1;
    step();
    CMD_ABORT = 1'b0;
    chk("abort_valid", TX_VALID, 1'b0);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_addr", RAM_RD_ADDR, 11'd0);
    chk("abort_fcnt", FRAME_CNT, 16'd5);
    got.delete();
    pulse_start(11'd12);
    n = 0;
    while (got.size() == 0 && n < 200) begin
      step();
      n++;
    end
    chk("abort_restart_hdr", (got.size() > 0) ? got[0] : 8'hxx, 8'hA5);
    wait_frame_end(6, 3000, "abort_restart_timeout");
    chk_stream("abort_restart_stream", 0);

    // Ignored events: CMD_START in WAIT_DONE, TURN_DONE in IDLE.
    ts_cyc.delete();
    pulse_start(11'd21);
    step(4);
    CFG_DIV = 11'd7;
    CMD_START = 1'b1;
    step();
    CMD_START = 1'b0;
    chk("ign_start_div", DIV_OUT, 11'd21);
    chk("ign_start_busy", BUSY, 1'b1);
    chk("ign_start_valid", TX_VALID, 1'b0);
    wait_frame_end(7, 3000, "ign_timeout");
    chk("ign_turns", ts_cyc.size(), 1);
    TURN_DONE = 1'b1;
    step();
    TURN_DONE = 1'b0;
    step(3);
    chk("ign_done_busy", BUSY, 1'b0);
    chk("ign_done_valid", TX_VALID, 1'b0);
    chk("ign_done_div", DIV_OUT, 11'd21);
    chk("ign_done_turns", ts_cyc.size(), 1);
    chk("ign_done_fcnt", FRAME_CNT, 16'd7);
    chk("div_stable", div_viol, 0);
    chk("addr_bound", addr_viol, 0);

    // Reset in the middle of a frame.
    ts_cyc.delete();
    pulse_start(11'd50);
    n = 0;
    while (!(TX_VALID && RAM_RD_ADDR > 11'd3) && n < 3000) begin
      step();
      n++;
    end
    chk("rst_mid_reach", (n < 3000), 1);
    RST = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    step(3);
    RST = 1'b1;
    step(10);
    chk("rst_after_busy", BUSY, 1'b0);
    chk("rst_after_valid", TX_VALID, 1'b0);
    chk("rst_after_div", DIV_OUT, 11'd4);
    chk("rst_after_fcnt", FRAME_CNT, 16'd0);
    chk("rst_after_turns", ts_cyc.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
